ram_responder: RTL and testbench

// Memory-side (responder) end of the MFA/MFC RAM handshake driven by the control unit.

---
 rtl/ram_pkg.sv | 31 +++
 rtl/ram_storage.sv | 31 +++
 rtl/ram_responder.sv | 116 +++++++++++
 tb/tb_ram_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared encodings for the MFA/MFC RAM responder: access sizes, direction, FSM states.
package ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [8:0] TRAP_ADDR = 9'd448;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } ram_state_e;

  // Lane 3 is the byte at the base address, so narrower accesses use the high lanes.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b1000;
      SZ_HALF: mask = 4'b1100;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ram_storage.sv
// Byte-wide storage array with a 4-lane byte-enable write port and a 4-byte read
// port, both at a common base address; lane 3 maps to base, lane 0 to base+3.
module ram_storage #(
  parameter int unsigned ADDR_W    = 9,
  parameter string       INIT_FILE = ""
) (
  input  logic              Clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[3-i]) mem[addr + ADDR_W'(i)] <= wdata[31-8*i -: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[31-8*i -: 8] = mem[addr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Responder end of the MFA/MFC RAM handshake: latches a request, waits a programmable
// number of cycles, performs a big-endian byte/half/word access and raises ramMFC.
module ram_responder
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              ramMFA,
  input  logic              ramRW,
  input  logic [1:0]        ramDataSize,
  input  logic [ADDR_W-1:0] ramAddress,
  input  logic [31:0]       ramDataIn,
  output logic [31:0]       ramDataOut,
  output logic              ramMFC,
  output logic              ramMisaligned
);

  ram_state_e        state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [31:0]       din_q;

  logic              misaligned;
  logic              fire;
  logic [3:0]        we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [31:0]       rd_ext;

  always_comb begin
    misaligned = 1'b0;
    if (size_q == SZ_HALF) misaligned = addr_q[0];
    else if (size_q[1])    misaligned = (addr_q[1:0] != 2'b00);
  end

  // Gate the write with reset so a reset landing on the completion edge commits nothing.
  assign fire = (state_q == StBusy) && (cnt_q == 4'd0) && reset;
  assign we   = (fire && rw_q == RW_WRITE && !misaligned) ? lane_mask(size_q) : 4'b0000;

  always_comb begin
    case (size_q)
      SZ_BYTE: begin
        wdata  = {din_q[7:0], 24'b0};
        rd_ext = {24'b0, rdata[31:24]};
      end
      SZ_HALF: begin
        wdata  = {din_q[15:0], 16'b0};
        rd_ext = {16'b0, rdata[31:16]};
      end
      default: begin
        wdata  = din_q;
        rd_ext = rdata;
      end
    endcase
  end

  ram_storage #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_storage (
    .Clk  (Clk),
    .addr (addr_q),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata)
  );

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      ramMFC        <= 1'b0;
      ramDataOut    <= 32'd0;
      ramMisaligned <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ramMFA) begin
            addr_q  <= ramAddress;
            rw_q    <= ramRW;
            size_q  <= ramDataSize;
            din_q   <= ramDataIn;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ramMFC        <= 1'b1;
            ramMisaligned <= misaligned;
            if (!misaligned && rw_q == RW_READ) ramDataOut <= rd_ext;
            state_q       <= StDone;
          end
        end
        StDone: begin
          // Four-phase: completion is held until the initiator withdraws MFA.
          if (!ramMFA) begin
            ramMFC        <= 1'b0;
            ramMisaligned <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: drives the initiator side on negedge and checks
// handshake timing, big-endian data, alignment traps and reset abort.
module tb_ram_responder;

  logic        Clk;
  logic        reset;
  logic        ramMFA;
  logic        ramRW;
  logic [1:0]  ramDataSize;
  logic [8:0]  ramAddress;
  logic [31:0] ramDataIn;
  logic [31:0] ramDataOut;
  logic        ramMFC;
  logic        ramMisaligned;

  int n_cmp = 0;
  int n_err = 0;

  ram_responder #(
    .ADDR_W     (9),
    .WAIT_CYCLES(2),
    .INIT_FILE  ("")
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .ramMFA       (ramMFA),
    .ramRW        (ramRW),
    .ramDataSize  (ramDataSize),
    .ramAddress   (ramAddress),
    .ramDataIn    (ramDataIn),
    .ramDataOut   (ramDataOut),
    .ramMFC       (ramMFC),
    .ramMisaligned(ramMisaligned)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // MFA is already high and about to be sampled at the next posedge; checks that MFC
  // appears after exactly 3 further posedges.
  task automatic wait_mfc(input string tag);
    int lat;
    lat = 99;
    for (int n = 0; n < 20; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (ramMFC === 1'b1) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd3);
  endtask

  task automatic access(input logic rw, input logic [1:0] sz, input logic [8:0] a,
                        input logic [31:0] d, input string tag,
                        output logic [31:0] dout, output logic mis);
    @(negedge Clk);
    ramRW       = rw;
    ramDataSize = sz;
    ramAddress  = a;
    ramDataIn   = d;
    ramMFA      = 1'b1;
    wait_mfc(tag);
    dout   = ramDataOut;
    mis    = ramMisaligned;
    ramMFA = 1'b0;
    @(negedge Clk);
    check_eq({tag, "_rel"}, 32'(ramMFC), 32'd0);
  endtask

  logic [31:0] dout;
  logic        mis;
  int          highs;

  initial begin
    reset       = 1'b0;
    ramMFA      = 1'b1;
    ramRW       = 1'b1;
    ramDataSize = 2'b00;
    ramAddress  = 9'h100;
    ramDataIn   = 32'h55;

    // Reset held with MFA high
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_eq("rst_mfc", 32'(ramMFC), 32'd0);
    check_eq("rst_dout", ramDataOut, 32'd0);
    check_eq("rst_mis", 32'(ramMisaligned), 32'd0);
    reset = 1'b1;
    wait_mfc("rst_accept");
    ramMFA = 1'b0;
    @(negedge Clk);
    check_eq("rst_accept_rel", 32'(ramMFC), 32'd0);
    check_eq("rst_accept_dout", ramDataOut, 32'd0);

    // Word write then byte reads
    access(1'b1, 2'b11, 9'h010, 32'hDEADBEEF, "wr_w10", dout, mis);
    check_eq("wr_w10_mis", 32'(mis), 32'd0);
    access(1'b0, 2'b00, 9'h010, 32'h0, "rd_b10", dout, mis);
    check_eq("rd_b10", dout, 32'h000000DE);
    access(1'b0, 2'b00, 9'h011, 32'h0, "rd_b11", dout, mis);
    check_eq("rd_b11", dout, 32'h000000AD);
    access(1'b0, 2'b00, 9'h012, 32'h0, "rd_b12", dout, mis);
    check_eq("rd_b12", dout, 32'h000000BE);
    access(1'b0, 2'b00, 9'h013, 32'h0, "rd_b13", dout, mis);
    check_eq("rd_b13", dout, 32'h000000EF);
    access(1'b0, 2'b01, 9'h012, 32'h0, "rd_h12", dout, mis);
    check_eq("rd_h12", dout, 32'h0000BEEF);

    // Half write into an initialised word
    access(1'b1, 2'b11, 9'h020, 32'hA5A55A5A, "wr_w20", dout, mis);
    access(1'b1, 2'b01, 9'h022, 32'hCAFE1234, "wr_h22", dout, mis);
    access(1'b0, 2'b10, 9'h020, 32'h0, "rd_w20", dout, mis);
    check_eq("rd_w20", dout, 32'hA5A51234);
    access(1'b0, 2'b00, 9'h023, 32'h0, "rd_b23", dout, mis);
    check_eq("rd_b23", dout, 32'h00000034);

    // Misaligned accesses
    access(1'b0, 2'b11, 9'h011, 32'h0, "mis_rd", dout, mis);
    check_eq("mis_rd_flag", 32'(mis), 32'd1);
    check_eq("mis_rd_dout", dout, 32'h00000034);
    access(1'b1, 2'b01, 9'h021, 32'h0000FFFF, "mis_wr", dout, mis);
    check_eq("mis_wr_flag", 32'(mis), 32'd1);
    check_eq("mis_wr_dout", dout, 32'h00000034);
    access(1'b0, 2'b11, 9'h020, 32'h0, "rd_w20b", dout, mis);
    check_eq("rd_w20b", dout, 32'hA5A51234);
    check_eq("rd_w20b_mis", 32'(mis), 32'd0);

    // Top-of-memory aligned word
    access(1'b1, 2'b11, 9'h1FC, 32'h01020304, "wr_top", dout, mis);
    access(1'b0, 2'b00, 9'h1FF, 32'h0, "rd_top", dout, mis);
    check_eq("rd_top", dout, 32'h00000004);

    // MFA held high after MFC: no re-accept even with changed data
    @(negedge Clk);
    ramRW       = 1'b1;
    ramDataSize = 2'b00;
    ramAddress  = 9'h030;
    ramDataIn   = 32'h77;
    ramMFA      = 1'b1;
    wait_mfc("hold");
    ramDataIn = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      check_eq("hold_mfc", 32'(ramMFC), 32'd1);
    end
    ramMFA = 1'b0;
    @(negedge Clk);
    check_eq("hold_rel", 32'(ramMFC), 32'd0);
    access(1'b0, 2'b00, 9'h030, 32'h0, "rd_b30", dout, mis);
    check_eq("rd_b30", dout, 32'h00000077);

    // MFA dropped during BUSY: write commits, MFC is a single-cycle pulse
    @(negedge Clk);
    ramRW       = 1'b1;
    ramDataSize = 2'b00;
    ramAddress  = 9'h031;
    ramDataIn   = 32'h66;
    ramMFA      = 1'b1;
    @(negedge Clk);
    ramMFA = 1'b0;
    highs  = 0;
    repeat (10) begin
      @(negedge Clk);
      if (ramMFC === 1'b1) highs++;
    end
    check_eq("pulse_cycles", 32'(highs), 32'd1);
    access(1'b0, 2'b00, 9'h031, 32'h0, "rd_b31", dout, mis);
    check_eq("rd_b31", dout, 32'h00000066);

    // Reset during BUSY aborts the write
    access(1'b1, 2'b00, 9'h040, 32'h11, "wr_b40", dout, mis);
    @(negedge Clk);
    ramRW       = 1'b1;
    ramDataSize = 2'b00;
    ramAddress  = 9'h040;
    ramDataIn   = 32'hFF;
    ramMFA      = 1'b1;
    @(negedge Clk);
    reset  = 1'b0;
    ramMFA = 1'b0;
    @(negedge Clk);
    check_eq("abort_mfc", 32'(ramMFC), 32'd0);
    check_eq("abort_dout", ramDataOut, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge Clk);
    check_eq("abort_idle_mfc", 32'(ramMFC), 32'd0);
    access(1'b0, 2'b00, 9'h040, 32'h0, "rd_b40", dout, mis);
    check_eq("rd_b40", dout, 32'h00000011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
